keypad_bcd_encoder: RTL and testbench

//  Input-side counterpart of the calculator's BCD-to-FND font path. Scans a 4x4 matrix keypad,

---
 rtl/calc_pkg.sv | 19 +
 rtl/scan_tick_gen.sv | 29 ++
 rtl/keypad_bcd_encoder.sv | 153 +++++++++++++++
 tb/tb_keypad_bcd_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes and keypad encoder FSM states.
// Digit keys 0-9 encode as their BCD value.
package calc_pkg;

  localparam logic [3:0] KEY_DP  = 4'hA;
  localparam logic [3:0] KEY_ADD = 4'hB;
  localparam logic [3:0] KEY_SUB = 4'hC;
  localparam logic [3:0] KEY_MUL = 4'hD;
  localparam logic [3:0] KEY_DIV = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } kp_state_e;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running dwell counter.
// Pulses o_tick on the last cycle of each SCAN_DIV-cycle period.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CntMax);
    cnt_d  = o_tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_bcd_encoder.sv
// 4x4 matrix keypad scanner with debounce.
// Emits a one-cycle o_valid strobe with the key code on each accepted press.
module keypad_bcd_encoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key,
  output logic       o_valid
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CNT);

  kp_state_e      state_q;
  logic [3:0]     row_meta_q, row_sync_q, cap_q;
  logic [3:0]     col_q, key_q;
  logic           valid_q;
  logic [DbW-1:0] cnt_q, rcnt_q;

  logic           tick;
  logic           rows_idle;
  logic [3:0]     col_next;
  logic [1:0]     col_idx, row_idx;
  logic [3:0]     key_code;
  logic [DbW-1:0] cnt_inc, rcnt_inc;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick_gen (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  always_comb begin
    rows_idle = &row_sync_q;
    col_next  = {col_q[2:0], col_q[3]};
    cnt_inc   = cnt_q + DbW'(1);
    rcnt_inc  = rcnt_q + DbW'(1);

    col_idx = 2'd0;
    unique case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase

    // Lowest row index wins when several rows are pulled low.
    if (!cap_q[0])      row_idx = 2'd0;
    else if (!cap_q[1]) row_idx = 2'd1;
    else if (!cap_q[2]) row_idx = 2'd2;
    else                row_idx = 2'd3;

    key_code = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = KEY_ADD;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = KEY_SUB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = KEY_MUL;
      4'b11_00: key_code = KEY_DP;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = KEY_EQ;
      4'b11_11: key_code = KEY_DIV;
      default:  key_code = 4'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StScan;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      cap_q      <= 4'hF;
      col_q      <= 4'b1110;
      key_q      <= 4'h0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
      valid_q    <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (tick) begin
            if (rows_idle) begin
              col_q <= col_next;
            end else begin
              cap_q   <= row_sync_q;
              cnt_q   <= DbW'(1);
              state_q <= StDebounce;
            end
          end
        end
        StDebounce: begin
          if (tick) begin
            if (row_sync_q == cap_q) begin
              cnt_q <= cnt_inc;
              // Code and strobe land together so o_valid is high only while in StPressed.
              if (cnt_inc == DbMax) begin
                key_q   <= key_code;
                valid_q <= 1'b1;
                state_q <= StPressed;
              end
            end else begin
              col_q   <= col_next;
              state_q <= StScan;
            end
          end
        end
        StPressed: begin
          rcnt_q  <= '0;
          state_q <= StRelease;
        end
        StRelease: begin
          if (tick) begin
            if (!rows_idle) begin
              rcnt_q <= '0;
            end else if (rcnt_inc == DbMax) begin
              rcnt_q  <= '0;
              col_q   <= col_next;
              state_q <= StScan;
            end else begin
              rcnt_q <= rcnt_inc;
            end
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign o_col   = col_q;
  assign o_key   = key_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: behavioural keypad matrix plus a scoreboard of expected
// key codes that is drained by a monitor on each o_valid strobe.
module tb_keypad_bcd_encoder;

  logic       clk;
  logic       i_reset;
  logic [3:0] i_row;
  logic [3:0] o_col;
  logic [3:0] o_key;
  logic       o_valid;

  logic [15:0] keys;  // keys[r*4+c] = key at row r, column c is held down
  logic [3:0]  sb[$];
  logic        valid_prev;
  int          n_checks;
  int          n_bad;

  keypad_bcd_encoder #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .i_row  (i_row),
    .o_col  (o_col),
    .o_key  (o_key),
    .o_valid(o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A held key shorts its row to its column; undriven rows float high.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial valid_prev = 1'b0;
  always @(negedge clk) begin
    if (o_valid) begin
      if (valid_prev) check_eq("valid_consecutive", 32'({o_valid, valid_prev}), 32'b01);
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        check_eq("key_code", 32'(o_key), 32'(sb.pop_front()));
      end
    end
    valid_prev <= o_valid;
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic press_release(input string tag, input logic [15:0] k, input logic [3:0] code,
                               input logic [3:0] col_exp, input int hold);
    int n;
    keys = k;
    sb.push_back(code);
    wait_drain(tag);
    check_eq({tag, "_col_frozen"}, 32'(o_col), 32'(col_exp));
    repeat (hold) @(negedge clk);
    check_eq({tag, "_col_held"}, 32'(o_col), 32'(col_exp));
    keys = '0;
    // Three high ticks plus synchroniser delay take well over 8 cycles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq({tag, "_col_release_hold"}, 32'(o_col), 32'(col_exp));
    end
    n = 0;
    while (o_col == col_exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_col_advance"}, 32'(o_col), 32'({col_exp[2:0], col_exp[3]}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_col;
    int n;
    n_checks = 0;
    n_bad    = 0;
    keys     = '0;
    i_reset  = 1'b1;

    // Reset state, then col0 dwell of 4 cycles.
    repeat (3) @(negedge clk);
    check_eq("rst_col", 32'(o_col), 32'h0000_000E);
    check_eq("rst_key", 32'(o_key), 32'd0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("dwell_col0", 32'(o_col), 32'h0000_000E);
      @(negedge clk);
    end
    check_eq("dwell_col1", 32'(o_col), 32'h0000_000D);

    // Idle scan: column walks every 4 cycles and wraps.
    for (int i = 0; i < 40; i++) begin
      exp_col = 4'hF;
      exp_col[(1 + i / 4) % 4] = 1'b0;
      check_eq("idle_scan", 32'(o_col), 32'(exp_col));
      @(negedge clk);
    end

    // '5' held ~60 cycles: one pulse, column frozen.
    press_release("key5", 16'h0020, 4'h5, 4'b1101, 50);

    // '7' bounce: low for exactly one tick sample while col0 is driven.
    n = 0;
    while (o_col == 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_col != 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bounce_align", 32'(o_col), 32'h0000_000E);
    keys = 16'h0100;
    repeat (4) @(negedge clk);
    keys = '0;
    for (int i = 0; i < 4; i++) begin
      check_eq("bounce_col_frozen", 32'(o_col), 32'h0000_000E);
      @(negedge clk);
    end
    check_eq("bounce_col_advance", 32'(o_col), 32'h0000_000D);

    // Multi-row in one column: lowest row ('2') wins; then '.' and '='.
    press_release("key2_8", 16'h0202, 4'h2, 4'b1101, 10);
    press_release("key_dp", 16'h1000, 4'hA, 4'b1110, 10);
    press_release("key_eq", 16'h4000, 4'hF, 4'b1011, 10);

    // Reset during RELEASE of '9', key still held afterwards.
    keys = 16'h0400;
    sb.push_back(4'h9);
    wait_drain("key9_first");
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_col", 32'(o_col), 32'h0000_000E);
    check_eq("mid_rst_key", 32'(o_key), 32'd0);
    check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
    i_reset = 1'b0;
    press_release("key9_again", 16'h0400, 4'h9, 4'b1011, 10);

    repeat (20) @(negedge clk);
    check_eq("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
